// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin AXI-stream arbiter.
// One registered output stage; optional beat watchdog truncates long packets.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   s_axis_*            PORTS packed input streams, per-port s_axis_tready
//   m_axis_*            registered output stream, m_axis_tid = source port
//   grant               one-hot current grant, zero while arbitrating
//   wdog_err            one-cycle pulse when a packet was truncated
module axis_packet_arbiter #(
   parameter int PORTS       = 4,
   parameter int TDATA_WIDTH = 8,
   parameter int STRB_WIDTH  = (TDATA_WIDTH + 7) / 8,
   parameter int ID_WIDTH    = (PORTS > 1) ? $clog2(PORTS) : 1,
   parameter int MAX_BEATS   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [PORTS*STRB_WIDTH-1:0]  s_axis_tstrb,
   input  logic [PORTS-1:0]             s_axis_tvalid,
   output logic [PORTS-1:0]             s_axis_tready,
   input  logic [PORTS-1:0]             s_axis_tlast,
   input  logic [PORTS-1:0]             s_axis_tfirst,
   output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
   output logic [STRB_WIDTH-1:0]        m_axis_tstrb,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tfirst,
   output logic [ID_WIDTH-1:0]          m_axis_tid,
   output logic [PORTS-1:0]             grant,
   output logic                         wdog_err
);

   localparam int CNT_W = 16;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                 r_state, w_state_nxt;
   logic [PORTS-1:0]       r_grant, w_grant_nxt;
   logic [ID_WIDTH-1:0]    r_gidx, w_gidx_nxt;
   logic [ID_WIDTH-1:0]    r_last, w_last_nxt;
   logic [CNT_W-1:0]       r_beat_cnt, w_beat_cnt_nxt;

   logic [TDATA_WIDTH-1:0] r_tdata;
   logic [STRB_WIDTH-1:0]  r_tstrb;
   logic                   r_tvalid;
   logic                   r_tlast;
   logic                   r_tfirst;
   logic [ID_WIDTH-1:0]    r_tid;
   logic                   r_wdog_err;

   logic                   w_out_free;
   logic                   w_xfer;
   logic                   w_wdog_hit;
   logic                   w_release;
   logic                   w_sel_valid;
   logic                   w_sel_last;
   logic                   w_sel_first;
   logic [TDATA_WIDTH-1:0] w_sel_data;
   logic [STRB_WIDTH-1:0]  w_sel_strb;
   logic [2*PORTS-1:0]     w_req_dbl;
   logic [PORTS-1:0]       w_req_rot;
   logic                   w_win_found;
   logic [ID_WIDTH-1:0]    w_win_idx;

   // Rotate requests so bit 0 is the port right after the last winner;
   // the lowest set bit of the rotated vector is then the fair choice.
   always_comb begin
      w_req_dbl   = {s_axis_tvalid, s_axis_tvalid} >> (32'(r_last) + 32'd1);
      w_req_rot   = w_req_dbl[PORTS-1:0];
      w_win_found = 1'b0;
      w_win_idx   = '0;
      for (int j = PORTS - 1; j >= 0; j--) begin
         if (w_req_rot[j]) begin
            w_win_found = 1'b1;
            w_win_idx   = ID_WIDTH'((int'(r_last) + 1 + j) % PORTS);
         end
      end
   end

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_first = 1'b0;
      w_sel_data  = '0;
      w_sel_strb  = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (r_gidx == ID_WIDTH'(i)) begin
            w_sel_valid = s_axis_tvalid[i];
            w_sel_last  = s_axis_tlast[i];
            w_sel_first = s_axis_tfirst[i];
            w_sel_data  = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            w_sel_strb  = s_axis_tstrb[i*STRB_WIDTH +: STRB_WIDTH];
         end
      end
   end

   assign w_out_free = !r_tvalid || m_axis_tready;
   assign w_xfer     = (r_state == ST_LOCKED) && w_out_free && w_sel_valid;
   assign w_wdog_hit = (MAX_BEATS != 0)
                    && (r_beat_cnt == CNT_W'(MAX_BEATS - 1))
                    && !w_sel_last;
   assign w_release  = w_xfer && (w_sel_last || w_wdog_hit);

   // r_grant is all-zero in IDLE, so no ready is offered while arbitrating.
   assign s_axis_tready = r_grant & {PORTS{w_out_free}};

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_gidx_nxt     = r_gidx;
      w_last_nxt     = r_last;
      w_beat_cnt_nxt = r_beat_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (w_win_found) begin
               w_state_nxt = ST_LOCKED;
               w_grant_nxt = PORTS'(1) << w_win_idx;
               w_gidx_nxt  = w_win_idx;
            end
         end
         ST_LOCKED: begin
            if (w_xfer) begin
               w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            end
            if (w_release) begin
               w_state_nxt    = ST_IDLE;
               w_grant_nxt    = '0;
               w_last_nxt     = r_gidx;
               w_beat_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_last     <= ID_WIDTH'(PORTS - 1);
         r_beat_cnt <= '0;
         r_tdata    <= '0;
         r_tstrb    <= '0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
         r_tfirst   <= 1'b0;
         r_tid      <= '0;
         r_wdog_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_gidx     <= w_gidx_nxt;
         r_last     <= w_last_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_wdog_err <= w_xfer && w_wdog_hit;
         if (w_xfer) begin
            r_tdata  <= w_sel_data;
            r_tstrb  <= w_sel_strb;
            r_tfirst <= w_sel_first;
            r_tlast  <= w_sel_last || w_wdog_hit;
            r_tid    <= r_gidx;
            r_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tstrb  = r_tstrb;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tfirst = r_tfirst;
   assign m_axis_tid    = r_tid;
   assign grant         = r_grant;
   assign wdog_err      = r_wdog_err;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: scoreboard bench for axis_packet_arbiter.
// Per-port reference queues, packet-level round-robin model, watchdog split.
`timescale 1ns/1ps
module tb_axis_packet_arbiter;

   localparam int P  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       f;
      logic       l;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [P*W-1:0] s_tdata;
   logic [P-1:0]   s_tstrb, s_tvalid, s_tready, s_tlast, s_tfirst;
   logic [W-1:0]   m_tdata;
   logic           m_tstrb, m_tvalid, m_tready, m_tlast, m_tfirst;
   logic [1:0]     m_tid;
   logic [P-1:0]   grant;
   logic           wdog_err;

   logic [P*W-1:0] d0_tdata;
   logic [P-1:0]   d0_tstrb, d0_tvalid, d0_tready, d0_tlast, d0_tfirst;
   logic [W-1:0]   d0m_tdata;
   logic           d0m_tstrb, d0m_tvalid, d0m_tready, d0m_tlast, d0m_tfirst;
   logic [1:0]     d0m_tid;
   logic [P-1:0]   d0_grant;
   logic           d0_wdog;

   axis_packet_arbiter #(.PORTS(P), .TDATA_WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tfirst(s_tfirst),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tfirst(m_tfirst),
      .m_axis_tid(m_tid), .grant(grant), .wdog_err(wdog_err));

   axis_packet_arbiter #(.PORTS(P), .TDATA_WIDTH(W), .MAX_BEATS(0)) dut0 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(d0_tdata), .s_axis_tstrb(d0_tstrb),
      .s_axis_tvalid(d0_tvalid), .s_axis_tready(d0_tready),
      .s_axis_tlast(d0_tlast), .s_axis_tfirst(d0_tfirst),
      .m_axis_tdata(d0m_tdata), .m_axis_tstrb(d0m_tstrb),
      .m_axis_tvalid(d0m_tvalid), .m_axis_tready(d0m_tready),
      .m_axis_tlast(d0m_tlast), .m_axis_tfirst(d0m_tfirst),
      .m_axis_tid(d0m_tid), .grant(d0_grant), .wdog_err(d0_wdog));

   int    checks = 0;
   int    errors = 0;
   beat_t src_q [P][$];
   beat_t exp_q [P][$];
   beat_t src0 [$];
   beat_t exp0 [$];
   logic [P-1:0] hs = '0;
   logic  hs0 = 1'b0;
   int    gap_pct = 0;
   int    rdy_mode = 0;
   int    exp_wdog = 0;
   int    wd_seen = 0;
   int    d0_wd_seen = 0;
   int    mdl_last = P - 1;
   int    tid_log [$];
   int    len_log [$];
   int    d0_len_log [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected output: source beats, with tlast forced every MB beats.
   task automatic gen_pkt(input int p, input int len, input bit fixed);
      for (int k = 1; k <= len; k++) begin
         beat_t b;
         beat_t e;
         b.d = fixed ? 8'(17 * k) : 8'($urandom_range(0, 255));
         b.s = 1'($urandom_range(0, 1));
         b.f = (k == 1);
         b.l = (k == len);
         e   = b;
         e.l = b.l || (k % MB == 0);
         if (k % MB == 0 && k != len) exp_wdog++;
         src_q[p].push_back(b);
         exp_q[p].push_back(e);
      end
   endtask

   task automatic gen0(input int len);
      for (int k = 1; k <= len; k++) begin
         beat_t b;
         b.d = 8'($urandom_range(0, 255));
         b.s = 1'b1;
         b.f = (k == 1);
         b.l = (k == len);
         src0.push_back(b);
         exp0.push_back(b);
      end
   endtask

   task automatic flush();
      for (int i = 0; i < P; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      src0.delete();
      exp0.delete();
      s_tvalid  = '0;
      d0_tvalid = '0;
      hs  = '0;
      hs0 = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < P; i++) begin
         if (hs[i]) begin
            void'(src_q[i].pop_front());
            s_tvalid[i] = 1'b0;
         end
      end
      if (hs0) begin
         void'(src0.pop_front());
         d0_tvalid[1] = 1'b0;
      end
      for (int i = 0; i < P; i++) begin
         if (!s_tvalid[i] && src_q[i].size() > 0
             && $urandom_range(0, 99) >= gap_pct) begin
            s_tvalid[i]       = 1'b1;
            s_tdata[i*W +: W] = src_q[i][0].d;
            s_tstrb[i]        = src_q[i][0].s;
            s_tfirst[i]       = src_q[i][0].f;
            s_tlast[i]        = src_q[i][0].l;
         end
      end
      if (!d0_tvalid[1] && src0.size() > 0) begin
         d0_tvalid[1]     = 1'b1;
         d0_tdata[W +: W] = src0[0].d;
         d0_tstrb[1]      = src0[0].s;
         d0_tfirst[1]     = src0[0].f;
         d0_tlast[1]      = src0[0].l;
      end
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = ($urandom_range(0, 9) < 7);
      endcase
      #1;
      hs  = s_tvalid & s_tready;
      hs0 = d0_tvalid[1] & d0_tready[1];
   endtask

   function automatic bit busy();
      bit b;
      b = m_tvalid || d0m_tvalid || (s_tvalid != 0) || (d0_tvalid != 0)
          || src0.size() > 0 || exp0.size() > 0;
      for (int i = 0; i < P; i++) begin
         if (src_q[i].size() > 0 || exp_q[i].size() > 0) b = 1'b1;
      end
      return b;
   endfunction

   task automatic drain(input string name);
      int n;
      n = 0;
      while (busy() && n < 3000) begin
         step();
         n++;
      end
      chk({name, "_drained"}, 32'(busy()), 32'd0);
      step();
      step();
   endtask

   task automatic log_chk(input string name, input int idx,
                          input int tid, input int len);
      if (idx < tid_log.size() && idx < len_log.size()) begin
         chk({name, "_tid"}, 32'(tid_log[idx]), 32'(tid));
         chk({name, "_len"}, 32'(len_log[idx]), 32'(len));
      end else begin
         checks++;
         errors++;
         $display("FAIL %s: packet %0d missing, got %0d packets",
                  name, idx, tid_log.size());
      end
   endtask

   task automatic clear_logs();
      tid_log.delete();
      len_log.delete();
      d0_len_log.delete();
   endtask

   // Monitor: pops per-port expectations, checks stall hold, ready
   // gating, packet contiguity and the round-robin choice.
   initial begin : monitor
      logic [P-1:0] prev_grant;
      logic [P-1:0] prev_req;
      logic         prev_stall;
      logic [12:0]  prev_out;
      logic         in_pkt;
      int           cur_tid, cur_len, d0_len, t, w, idx;
      beat_t        e;
      prev_grant = '0;
      prev_req   = '0;
      prev_stall = 1'b0;
      prev_out   = '0;
      in_pkt     = 1'b0;
      cur_tid    = 0;
      cur_len    = 0;
      d0_len     = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            prev_grant = '0;
            prev_req   = '0;
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
            d0_len     = 0;
            mdl_last   = P - 1;
         end else begin
            if (wdog_err) wd_seen++;
            if (d0_wdog) d0_wd_seen++;
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            chk("ready_outside_grant", 32'(s_tready & ~grant), 32'd0);
            if (m_tvalid && !m_tready) begin
               chk("ready_while_full", 32'(s_tready), 32'd0);
            end
            if (prev_stall) begin
               chk("stall_valid_held", 32'(m_tvalid), 32'd1);
               chk("stall_data_held",
                   32'({m_tdata, m_tstrb, m_tlast, m_tfirst, m_tid}),
                   32'(prev_out));
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tdata, m_tstrb, m_tlast, m_tfirst, m_tid};
            if (m_tvalid && m_tready) begin
               t = int'(m_tid);
               if (exp_q[t].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: tid %0d data 0x%0h",
                           t, m_tdata);
               end else begin
                  e = exp_q[t].pop_front();
                  chk("out_data", 32'(m_tdata), 32'(e.d));
                  chk("out_strb", 32'(m_tstrb), 32'(e.s));
                  chk("out_last", 32'(m_tlast), 32'(e.l));
                  chk("out_first", 32'(m_tfirst), 32'(e.f));
               end
               if (in_pkt) begin
                  chk("contiguous_tid", 32'(t), 32'(cur_tid));
               end else begin
                  in_pkt  = 1'b1;
                  cur_tid = t;
                  cur_len = 0;
                  tid_log.push_back(t);
               end
               cur_len++;
               if (m_tlast) begin
                  in_pkt = 1'b0;
                  len_log.push_back(cur_len);
               end
            end
            if (d0m_tvalid && d0m_tready) begin
               if (exp0.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL d0_unexpected_beat: data 0x%0h", d0m_tdata);
               end else begin
                  e = exp0.pop_front();
                  chk("d0_data", 32'(d0m_tdata), 32'(e.d));
                  chk("d0_last", 32'(d0m_tlast), 32'(e.l));
                  chk("d0_tid", 32'(d0m_tid), 32'd1);
               end
               d0_len++;
               if (d0m_tlast) begin
                  d0_len_log.push_back(d0_len);
                  d0_len = 0;
               end
            end
            if (grant != 0 && prev_grant == 0) begin
               w = -1;
               for (int k = 1; k <= P; k++) begin
                  idx = (mdl_last + k) % P;
                  if (w < 0 && prev_req[idx]) w = idx;
               end
               if (w < 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rr_grant_without_request: grant 0x%0h",
                           grant);
               end else begin
                  chk("rr_winner", 32'(grant), 32'(1) << w);
               end
            end
            if (grant == 0 && prev_grant != 0) begin
               for (int k = 0; k < P; k++) begin
                  if (prev_grant[k]) mdl_last = k;
               end
            end
            prev_grant = grant;
            prev_req   = s_tvalid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int n;
      int wd0;
      s_tdata = '0; s_tstrb = '0; s_tvalid = '0;
      s_tlast = '0; s_tfirst = '0; m_tready = 1'b0;
      d0_tdata = '0; d0_tstrb = '0; d0_tvalid = '0;
      d0_tlast = '0; d0_tfirst = '0; d0m_tready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_tfirst", 32'(m_tfirst), 32'd0);
      chk("rst_tid", 32'(m_tid), 32'd0);
      chk("rst_tdata", 32'({m_tdata, m_tstrb}), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_sready", 32'(s_tready), 32'd0);
      chk("rst_wdog", 32'(wdog_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // single port, latency
      clear_logs();
      rdy_mode = 0;
      gen_pkt(2, 3, 1'b1);
      step();
      n = 0;
      while (!m_tvalid && n < 10) begin
         step();
         n++;
         if (n == 1) chk("latency_grant", 32'(grant), 32'b0100);
      end
      chk("latency_first_valid", 32'(n), 32'd2);
      drain("single");
      chk("single_pkts", 32'(tid_log.size()), 32'd1);
      log_chk("single", 0, 2, 3);

      // round robin, all ports busy
      @(negedge clk);
      rst = 1'b0;
      flush();
      @(negedge clk);
      rst = 1'b1;
      clear_logs();
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < P; p++) gen_pkt(p, 2, 1'b0);
      drain("rr");
      chk("rr_pkts", 32'(tid_log.size()), 32'd12);
      for (int k = 0; k < 12; k++) log_chk("rr_seq", k, k % P, 2);

      // backpressure
      clear_logs();
      rdy_mode = 1;
      gen_pkt(0, 4, 1'b0);
      drain("bp");
      rdy_mode = 0;
      chk("bp_pkts", 32'(tid_log.size()), 32'd1);
      log_chk("bp", 0, 0, 4);

      // watchdog split, and the same packet with the watchdog disabled
      clear_logs();
      wd0 = wd_seen;
      gen_pkt(1, 6, 1'b0);
      gen0(6);
      drain("wdog");
      chk("wdog_pulses", 32'(wd_seen - wd0), 32'd1);
      chk("wdog_pkts", 32'(tid_log.size()), 32'd2);
      log_chk("wdog_head", 0, 1, 4);
      log_chk("wdog_tail", 1, 1, 2);
      chk("nowdog_pkts", 32'(d0_len_log.size()), 32'd1);
      if (d0_len_log.size() > 0)
         chk("nowdog_len", 32'(d0_len_log[0]), 32'd6);

      // simultaneous request right after port 0 finished
      gen_pkt(0, 1, 1'b0);
      drain("simul_pre");
      clear_logs();
      gen_pkt(0, 2, 1'b0);
      gen_pkt(3, 2, 1'b0);
      drain("simul");
      log_chk("simul_first", 0, 3, 2);
      log_chk("simul_second", 1, 0, 2);

      // reset during beat 2 of a port 0 packet
      gen_pkt(0, 3, 1'b0);
      n = 0;
      while (!m_tvalid && n < 10) begin
         step();
         n++;
      end
      chk("midrst_started", 32'(m_tvalid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      flush();
      @(posedge clk);
      #1;
      chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
      chk("midrst_outs", 32'({m_tdata, m_tstrb, m_tlast, m_tfirst, m_tid}),
          32'd0);
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_sready", 32'(s_tready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      clear_logs();
      gen_pkt(3, 2, 1'b0);
      step();
      n = 0;
      while (grant == 0 && n < 5) begin
         step();
         n++;
      end
      chk("postrst_grant", 32'(grant), 32'b1000);
      chk("postrst_grant_cycle", 32'(n), 32'd1);
      drain("postrst");
      log_chk("postrst", 0, 3, 2);

      // randomized traffic
      clear_logs();
      gap_pct  = 30;
      rdy_mode = 2;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            n = int'($urandom_range(0, P - 1));
            if (src_q[n].size() < 10) gen_pkt(n, int'($urandom_range(1, 9)), 1'b0);
         end
         step();
      end
      drain("random");
      rdy_mode = 0;
      gap_pct  = 0;

      chk("wdog_total", 32'(wd_seen), 32'(exp_wdog));
      chk("nowdog_no_pulse", 32'(d0_wd_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
